rom_port_arbiter: RTL and testbench

Shares the single combinational instruction ROM between two requesters: the instruction-fetch stage (IF) and a load/debug read path (LS) that reads constants from ROM. Each cycle it grants at most one requester, drives the ROM chip-enable and address, and returns the read word one cycle later. Fetch has priority, and a starvation counter guarantees LS forward progress. Sits between the fetch/LS logic and inst_rom in the CPU top.

---
 rtl/rom_port_arbiter_pkg.sv | 30 +++
 rtl/rom_port_arbiter.sv | 107 ++++++++++
 tb/tb_rom_port_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/rom_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rom_port_arbiter_pkg
// Brief   : Shared CPU defines for the ROM port arbiter (bus widths, enables).
// Revision: 1.0 - initial release
// ============================================================================
package rom_port_arbiter_pkg;

  localparam int INST_ADDR_BUS = 32;
  localparam int INST_BUS      = 32;
  localparam int DEFAULT_ROM_AW = 5;

  localparam logic [INST_BUS-1:0] ZERO_WORD    = 32'h0;
  localparam logic                CHIP_ENABLE  = 1'b1;
  localparam logic                CHIP_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_LS   = 2'd2
  } grant_e;

  // A byte address is usable only if word aligned and inside the 2**aw-word ROM.
  function automatic logic addr_invalid(input logic [INST_ADDR_BUS-1:0] addr,
                                        input int aw);
    return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != '0);
  endfunction

endpackage : rom_port_arbiter_pkg
`default_nettype wire

// File: rtl/rom_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rom_port_arbiter
// Brief   : Fetch-priority arbiter sharing one combinational instruction ROM
//           between fetch and a load/debug path, with LS starvation guard.
// Revision: 1.0 - initial release
// ============================================================================
module rom_port_arbiter
  import rom_port_arbiter_pkg::*;
#(
  parameter int ROM_AW   = DEFAULT_ROM_AW,
  parameter int MAX_WAIT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_req,
  input  logic [INST_ADDR_BUS-1:0] if_addr,
  output logic                     if_gnt,
  output logic                     if_rvalid,
  output logic [INST_BUS-1:0]      if_rdata,
  output logic                     if_err,
  input  logic                     ls_req,
  input  logic [INST_ADDR_BUS-1:0] ls_addr,
  output logic                     ls_gnt,
  output logic                     ls_rvalid,
  output logic [INST_BUS-1:0]      ls_rdata,
  output logic                     ls_err,
  output logic                     rom_ce,
  output logic [INST_ADDR_BUS-1:0] rom_addr,
  input  logic [INST_BUS-1:0]      rom_inst
);

  localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0]         starve_cnt;
  logic                     ls_pri;
  grant_e                   grant;
  logic [INST_ADDR_BUS-1:0] sel_addr;
  logic                     sel_err;
  logic [INST_BUS-1:0]      rsp_data;

  assign ls_pri = (starve_cnt == CNT_MAX);

  always_comb begin
    grant = GNT_NONE;
    if (!rst) begin
      if (ls_req && (!if_req || ls_pri)) begin
        grant = GNT_LS;
      end else if (if_req) begin
        grant = GNT_IF;
      end
    end
  end

  always_comb begin
    sel_addr = (grant == GNT_LS) ? ls_addr : if_addr;
    sel_err  = addr_invalid(sel_addr, ROM_AW);
    if_gnt   = (grant == GNT_IF);
    ls_gnt   = (grant == GNT_LS);
    rom_ce   = CHIP_DISABLE;
    rom_addr = ZERO_WORD;
    // Bad addresses still retire through a grant but never touch the ROM.
    if ((grant != GNT_NONE) && !sel_err) begin
      rom_ce   = CHIP_ENABLE;
      rom_addr = sel_addr;
    end
    rsp_data = sel_err ? ZERO_WORD : rom_inst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_rvalid <= 1'b0;
      if_err    <= 1'b0;
      if_rdata  <= ZERO_WORD;
      ls_rvalid <= 1'b0;
      ls_err    <= 1'b0;
      ls_rdata  <= ZERO_WORD;
    end else begin
      if_rvalid <= (grant == GNT_IF);
      if_err    <= (grant == GNT_IF) && sel_err;
      ls_rvalid <= (grant == GNT_LS);
      ls_err    <= (grant == GNT_LS) && sel_err;
      if (grant == GNT_IF) begin
        if_rdata <= rsp_data;
      end
      if (grant == GNT_LS) begin
        ls_rdata <= rsp_data;
      end
    end
  end

  // Counts consecutive refused LS cycles; saturation hands LS the priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (ls_req && !ls_gnt) begin
      if (starve_cnt != CNT_MAX) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end else begin
      starve_cnt <= '0;
    end
  end

endmodule : rom_port_arbiter
`default_nettype wire

// File: tb/tb_rom_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_rom_port_arbiter
// Brief   : Self-checking bench; two arbiters (MAX_WAIT 4 and 0) on shared stimulus.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rom_port_arbiter;

  logic clk;
  logic rst;
  logic if_req, ls_req;
  logic [31:0] if_addr, ls_addr;
  logic [1:0] if_gnt, if_rvalid, if_err, ls_gnt, ls_rvalid, ls_err, rom_ce;
  logic [1:0][31:0] if_rdata, ls_rdata, rom_addr, rom_inst;
  logic [31:0] rom_mem [32];

  int errors = 0;
  int checks = 0;

  int   mw [2] = '{4, 0};
  int   cnt [2];
  logic m_if_rv [2], m_if_err [2], m_ls_rv [2], m_ls_err [2];
  logic [31:0] m_if_rd [2], m_ls_rd [2];
  logic last_if_gnt [2], last_ls_gnt [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 32; i++) rom_mem[i] = 32'hA000_0000 + i;
  end

  // Disabled ROM returns junk so a missing zeroing of error data shows up.
  assign rom_inst[0] = rom_ce[0] ? rom_mem[rom_addr[0][6:2]] : 32'hDEAD_BEEF;
  assign rom_inst[1] = rom_ce[1] ? rom_mem[rom_addr[1][6:2]] : 32'hDEAD_BEEF;

  rom_port_arbiter #(.ROM_AW(5), .MAX_WAIT(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[0]),
    .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]), .if_err(if_err[0]),
    .ls_req(ls_req), .ls_addr(ls_addr), .ls_gnt(ls_gnt[0]),
    .ls_rvalid(ls_rvalid[0]), .ls_rdata(ls_rdata[0]), .ls_err(ls_err[0]),
    .rom_ce(rom_ce[0]), .rom_addr(rom_addr[0]), .rom_inst(rom_inst[0])
  );

  rom_port_arbiter #(.ROM_AW(5), .MAX_WAIT(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[1]),
    .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]), .if_err(if_err[1]),
    .ls_req(ls_req), .ls_addr(ls_addr), .ls_gnt(ls_gnt[1]),
    .ls_rvalid(ls_rvalid[1]), .ls_rdata(ls_rdata[1]), .ls_err(ls_err[1]),
    .rom_ce(rom_ce[1]), .rom_addr(rom_addr[1]), .rom_inst(rom_inst[1])
  );

  task automatic chk(input string tag, input int k, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check combinational outputs mid-cycle,
  // advance the reference model, then check the registered response.
  task automatic step(input logic r, input logic iq, input logic [31:0] ia,
                      input logic lq, input logic [31:0] la);
    logic gl, gi, bad, ce;
    logic [31:0] a, d;
    rst = r; if_req = iq; if_addr = ia; ls_req = lq; ls_addr = la;
    #4;
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        gl = 1'b0; gi = 1'b0;
      end else begin
        gl = lq && (!iq || cnt[k] == mw[k]);
        gi = iq && !gl;
      end
      a   = gl ? la : ia;
      bad = (a[1:0] != 2'b00) || (a >= 32'd128);
      ce  = (gi || gl) && !bad;
      d   = bad ? 32'h0 : rom_mem[a[6:2]];
      chk("if_gnt", k, 32'(if_gnt[k]), 32'(gi));
      chk("ls_gnt", k, 32'(ls_gnt[k]), 32'(gl));
      chk("rom_ce", k, 32'(rom_ce[k]), 32'(ce));
      chk("rom_addr", k, rom_addr[k], ce ? a : 32'h0);
      last_if_gnt[k] = if_gnt[k];
      last_ls_gnt[k] = ls_gnt[k];
      if (r) begin
        m_if_rv[k] = 0; m_if_err[k] = 0; m_if_rd[k] = 0;
        m_ls_rv[k] = 0; m_ls_err[k] = 0; m_ls_rd[k] = 0;
        cnt[k] = 0;
      end else begin
        m_if_rv[k]  = gi;
        m_if_err[k] = gi && bad;
        if (gi) m_if_rd[k] = d;
        m_ls_rv[k]  = gl;
        m_ls_err[k] = gl && bad;
        if (gl) m_ls_rd[k] = d;
        cnt[k] = (lq && !gl) ? ((cnt[k] < mw[k]) ? cnt[k] + 1 : mw[k]) : 0;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("if_rvalid", k, 32'(if_rvalid[k]), 32'(m_if_rv[k]));
      chk("if_err", k, 32'(if_err[k]), 32'(m_if_err[k]));
      chk("if_rdata", k, if_rdata[k], m_if_rd[k]);
      chk("ls_rvalid", k, 32'(ls_rvalid[k]), 32'(m_ls_rv[k]));
      chk("ls_err", k, 32'(ls_err[k]), 32'(m_ls_err[k]));
      chk("ls_rdata", k, ls_rdata[k], m_ls_rd[k]);
    end
  endtask

  function automatic logic [31:0] rnd_addr();
    case ($urandom_range(0, 9))
      0:       return $urandom;
      1:       return {25'h0, 5'($urandom), 2'($urandom_range(1, 3))};
      2:       return {24'h0, 1'b1, 5'($urandom), 2'b00};
      default: return {25'h0, 5'($urandom), 2'b00};
    endcase
  endfunction

  initial begin
    rst = 1'b1; if_req = 1'b0; ls_req = 1'b0; if_addr = '0; ls_addr = '0;
    for (int k = 0; k < 2; k++) cnt[k] = 0;

    // Reset, release, single fetch
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 32'h8, 0, 0);
    chk("fetch8_gnt", 0, 32'(last_if_gnt[0]), 32'd1);
    chk("fetch8_rdata", 0, if_rdata[0], 32'hA000_0002);
    chk("fetch8_rvalid", 0, 32'(if_rvalid[0]), 32'd1);

    // Starvation: IF continuous, LS pending at 0x4
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 32'h0, 1, 32'h4);
      chk("starve_ls_gnt", 0, 32'(last_ls_gnt[0]), (i == 4) ? 32'd1 : 32'd0);
      chk("pri0_if_gnt", 1, 32'(last_if_gnt[1]), 32'd0);
      chk("pri0_ls_gnt", 1, 32'(last_ls_gnt[1]), 32'd1);
    end
    chk("starve_ls_rvalid", 0, 32'(ls_rvalid[0]), 32'd1);
    chk("starve_ls_rdata", 0, ls_rdata[0], 32'hA000_0001);
    step(0, 1, 32'h0, 1, 32'h4);
    chk("cnt_cleared_if_wins", 0, 32'(last_if_gnt[0]), 32'd1);
    step(0, 0, 0, 0, 0);

    // LS error accesses
    step(0, 0, 0, 1, 32'h6);
    chk("mis_err", 0, 32'(ls_err[0]), 32'd1);
    chk("mis_rdata", 0, ls_rdata[0], 32'h0);
    step(0, 0, 0, 1, 32'h80);
    chk("oor_err", 0, 32'(ls_err[0]), 32'd1);
    chk("oor_rvalid", 0, 32'(ls_rvalid[0]), 32'd1);

    // Back-to-back fetches
    step(0, 1, 32'h0, 0, 0);
    chk("b2b_0", 0, if_rdata[0], 32'hA000_0000);
    step(0, 1, 32'h4, 0, 0);
    chk("b2b_1", 0, if_rdata[0], 32'hA000_0001);
    step(0, 1, 32'hC, 0, 0);
    chk("b2b_2", 0, if_rdata[0], 32'hA000_0003);

    // Reset right after a grant drops the response
    step(0, 1, 32'h8, 1, 32'h10);
    step(1, 1, 32'h8, 1, 32'h10);
    chk("rst_if_rvalid", 0, 32'(if_rvalid[0]), 32'd0);
    chk("rst_if_rdata", 0, if_rdata[0], 32'h0);
    step(0, 0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 3) != 0), rnd_addr(),
           1'($urandom_range(0, 2) != 0), rnd_addr());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_rom_port_arbiter
`default_nettype wire
